// File: rtl/gray_step_counter.sv
// gray_step_counter: up/down count presented as registered Gray code with change/limit strobes.
// Optional GRAY_CHECK_EN adds a sticky Gray-adjacency error flag on ERR.
module gray_step_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0,
  parameter int INIT     = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP,
  input  logic             DOWN,
  input  logic             CLR,
  output logic [WIDTH-1:0] BIN,
  output logic [WIDTH-1:0] GRAY,
  output logic             CHG,
  output logic             LIMIT,
  output logic             ERR
);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_G = INIT_V ^ (INIT_V >> 1);
  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             chgd_q, chgd_d, lim_q, lim_d, chg_q, inc, dec;
  always_comb begin
    inc    = !CLR && UP && !DOWN;
    dec    = !CLR && DOWN && !UP;
    lim_d  = (inc && bin_q == MAX_V) || (dec && bin_q == '0);
    bin_d  = CLR ? INIT_V : (lim_d && SATURATE) ? bin_q : inc ? bin_q + ONE_V : dec ? bin_q - ONE_V : bin_q;
    chgd_d = bin_d != bin_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_q  <= INIT_V;
      chgd_q <= 1'b0;
      lim_q  <= 1'b0;
      gray_q <= INIT_G;
      chg_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      chgd_q <= chgd_d;
      lim_q  <= lim_d;
      gray_q <= bin_q ^ (bin_q >> 1);
      chg_q  <= chgd_q;
    end
  end
  assign BIN   = bin_q;
  assign GRAY  = gray_q;
  assign CHG   = chg_q;
  assign LIMIT = lim_q;
`ifdef GRAY_CHECK_EN
  // clear tag travels alongside the change bit so clears are exempt from the adjacency check
  logic [WIDTH-1:0] prev_q;
  logic             clr1_q, clr2_q, err_q, err_d;
  always_comb err_d = CLR ? 1'b0 : err_q | (chg_q && !clr2_q && $countones(gray_q ^ prev_q) != 1);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q <= INIT_G;
      clr1_q <= 1'b0;
      clr2_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= gray_q;
      clr1_q <= CLR;
      clr2_q <= clr1_q;
      err_q  <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_gray_step_counter.sv
// tb_gray_step_counter: scoreboard bench for a wrapping (INIT=0) and a saturating (INIT=3) instance.
module tb_gray_step_counter;
  typedef struct {int bin; int lim; int chg;} exp_t;
  localparam int INIT_A = 0, INIT_B = 3;
  logic clk = 1'b0, rst = 1'b0, up = 1'b0, dn = 1'b0, clr = 1'b0;
  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic chg_a, lim_a, err_a, chg_b, lim_b, err_b;
  int errors = 0, checks = 0;
  int mb_a = INIT_A, mb_b = INIT_B;
  exp_t qa[$], qb[$];

  always #5 clk = ~clk;

  gray_step_counter #(.WIDTH(4), .SATURATE(1'b0), .INIT(INIT_A)) dut_a (
    .CLK(clk), .RST(rst), .UP(up), .DOWN(dn), .CLR(clr),
    .BIN(bin_a), .GRAY(gray_a), .CHG(chg_a), .LIMIT(lim_a), .ERR(err_a));
  gray_step_counter #(.WIDTH(4), .SATURATE(1'b1), .INIT(INIT_B)) dut_b (
    .CLK(clk), .RST(rst), .UP(up), .DOWN(dn), .CLR(clr),
    .BIN(bin_b), .GRAY(gray_b), .CHG(chg_b), .LIMIT(lim_b), .ERR(err_b));

  function automatic int g(int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer step with out-of-range detection, then wrap or hold.
  function automatic exp_t model(inout int b, input int sat, input int init, input logic [2:0] c);
    exp_t e;
    int n = b;
    e.lim = 0;
    if (c[2]) n = init;
    else if (c[1] && !c[0]) n = b + 1;
    else if (c[0] && !c[1]) n = b - 1;
    if (n > 15 || n < 0) begin
      e.lim = 1;
      n = sat ? b : (n + 16) % 16;
    end
    e.chg = (n != b);
    e.bin = n;
    b = n;
    return e;
  endfunction

  task automatic cmd(logic [2:0] c);
    @(negedge clk);
    {clr, up, dn} = c;
    qa.push_back(model(mb_a, 0, INIT_A, c));
    qb.push_back(model(mb_b, 1, INIT_B, c));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cmd(3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {clr, up, dn} = 3'b000;
    rst = 1'b0;
    #1;
    chk("rst_bin_a", bin_a, INIT_A);
    chk("rst_bin_b", bin_b, INIT_B);
    chk("rst_gray_a", gray_a, g(INIT_A));
    chk("rst_gray_b", gray_b, g(INIT_B));
    chk("rst_chg", {chg_a, chg_b}, 0);
    chk("rst_lim", {lim_a, lim_b}, 0);
    chk("rst_err", {err_a, err_b}, 0);
    qa.delete();
    qb.delete();
    mb_a = INIT_A;
    mb_b = INIT_B;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops one expectation per cycle; GRAY/CHG are checked a cycle after their BIN/LIMIT.
  initial begin
    int eg_a, eg_b, ec_a, ec_b;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        eg_a = g(INIT_A); eg_b = g(INIT_B); ec_a = 0; ec_b = 0;
      end else begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("bin_a", bin_a, e.bin);
          chk("lim_a", lim_a, e.lim);
          chk("gray_a", gray_a, eg_a);
          chk("chg_a", chg_a, ec_a);
          eg_a = g(e.bin); ec_a = e.chg;
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("bin_b", bin_b, e.bin);
          chk("lim_b", lim_b, e.lim);
          chk("gray_b", gray_b, eg_b);
          chk("chg_b", chg_b, ec_b);
          eg_b = g(e.bin); ec_b = e.chg;
        end
        chk("err", {err_a, err_b}, 0);
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd(3'b010);
      idle(39);
    end
    for (int i = 0; i < 12; i++) cmd(3'b010);
    idle(2);
    cmd(3'b010);
    idle(2);
    cmd(3'b001);
    idle(2);
    cmd(3'b100);
    for (int i = 0; i < 4; i++) cmd(3'b001);
    idle(2);
    cmd(3'b100);
    cmd(3'b010);
    cmd(3'b010);
    cmd(3'b011);
    idle(2);
    cmd(3'b110);
    idle(2);
    cmd(3'b100);
    idle(2);
    for (int i = 0; i < 4; i++) cmd(3'b010);
    idle(2);
    cmd(3'b010);
    do_reset();
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      cmd(r < 3 ? 3'b100 : r < 8 ? 3'(r) : r < 50 ? 3'b010 : r < 85 ? 3'b001 : 3'b000);
    end
    idle(3);
    @(negedge clk);
    chk("queues_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Consumer of the debounced single-cycle button pulses (40 Hz-gated, one CLK wide) produced by the button-debounce stage.
- Keeps an up/down binary count and presents it as registered Gray code for LED display.
- Emits change and limit strobes for downstream display logic.
- Sits between the per-button debounce instances and the LED/output pins.

Parameters:
- WIDTH, 4, counter and Gray output width in bits (2..16).
- SATURATE, 0, 0 = wrap at both ends; 1 = hold at 0 and at 2^WIDTH-1.
- INIT, 0, binary reset/clear value of the count; must be < 2^WIDTH.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- UP  input  1  debounced increment pulse, one CLK wide.
- DOWN  input  1  debounced decrement pulse, one CLK wide.
- CLR  input  1  debounced clear pulse, one CLK wide.
- BIN  output  WIDTH  registered binary count.
- GRAY  output  WIDTH  registered Gray code of BIN, one cycle behind BIN.
- CHG  output  1  one-cycle strobe, aligned with a GRAY update.
- LIMIT  output  1  one-cycle strobe: step requested at a boundary.
- ERR  output  1  Gray-adjacency error flag (GRAY_CHECK_EN only; otherwise tied 0).

Behaviour:
- Reset: RST low asynchronously forces BIN=INIT, GRAY=INIT^(INIT>>1), CHG=0, LIMIT=0, ERR=0 and all internal registers to these values. Sampling resumes on the first CLK edge after RST rises.
- Command decode, per cycle, in priority order:
  - CLR=1: clear; UP and DOWN are ignored.
  - UP=1 and DOWN=1 together: no-op; no strobes.
  - UP alone: step +1.
  - DOWN alone: step -1.
  - None asserted: hold.
- Stage 1 (edge after pulse, N+1): BIN updates.
  - +1 at 2^WIDTH-1: SATURATE=0 gives BIN=0; SATURATE=1 holds BIN. LIMIT=1 in both modes.
  - -1 at 0: SATURATE=0 gives BIN=2^WIDTH-1; SATURATE=1 holds BIN. LIMIT=1 in both modes.
  - Arithmetic is modulo 2^WIDTH; no carry out is exposed.
  - Clear: BIN=INIT. LIMIT is never asserted by a clear.
  - Stage 1 also registers a "changed" bit = (new BIN != old BIN).
- Stage 2 (N+2): GRAY <= BIN ^ (BIN>>1), and CHG <= registered changed bit.
  - CHG=0 when the value was unchanged: saturated step, clear while already at INIT, no-op, or hold.
- LIMIT is a one-cycle pulse at N+1. It is not stretched.
- Throughput: one command per cycle. Back-to-back pulses on consecutive cycles each take effect; no command is dropped.
- GRAY changes by exactly one bit for every ±1 step, including the wrap step. A clear may change multiple bits.
- Outputs are registers only; there are no combinational paths from inputs to outputs.
- RST asserted mid-pipeline discards any in-flight update; no CHG is emitted after reset release.

Optional Feature:
- Macro GRAY_CHECK_EN.
- Defined:
  - A shadow register holds the previous GRAY.
  - On each CHG cycle that was not caused by a clear, if popcount(GRAY ^ previous) != 1, ERR is set.
  - ERR is sticky until RST or CLR.
  - The step/clear tag is carried through stage 2 to make this distinction.
- Not defined: no shadow register, no tag pipeline; ERR is driven constant 0.

Test Plan (WIDTH=4, INIT=0 unless stated):
- Reset with RST=0 then release -> BIN=0, GRAY=0000, CHG=0, LIMIT=0, ERR=0.
- Three UP pulses, 40 cycles apart -> BIN 1,2,3 at N+1; GRAY 0001, 0011, 0010 at N+2; one CHG per pulse.
- SATURATE=0, BIN=15, UP -> BIN=0 and LIMIT=1 at N+1; GRAY 1000->0000 with CHG=1 at N+2. Then DOWN -> BIN=15, LIMIT=1, GRAY=1000.
- SATURATE=1, BIN=0, DOWN -> BIN stays 0, LIMIT=1 for one cycle, CHG=0 at N+2, GRAY stays 0000.
- UP and DOWN in the same cycle at BIN=5 -> no change, no strobes. CLR with UP at BIN=5, INIT=3 -> BIN=3, GRAY=0010, CHG=1, LIMIT=0.
- UP pulses on 4 consecutive cycles from 0 -> BIN reaches 4; 4 CHG strobes. With GRAY_CHECK_EN, ERR stays 0 throughout; forcing GRAY via the bench to a 2-bit jump sets ERR=1 until CLR.
